// File: rtl/ramdisk_fill_engine.sv
// Background SRAM fill/verify sequencer for the RAM-disk card. Steals one byte
// access per Apple II bus cycle (S1-S3) while the 6502 port owns S4-S7.
module ramdisk_fill_engine #(
   parameter int AW = 20  // 17..24: address and length are exposed as three bytes
) (
   input  logic          C7M,
   input  logic          RES,
   input  logic [2:0]    S,
   input  logic          HostReq,
   input  logic          CfgWR,
   input  logic [2:0]    CfgSel,
   input  logic [7:0]    CfgD,
   output logic [7:0]    CfgQ,
   output logic [AW-1:0] RAMA,
   output logic [7:0]    RAMDO,
   input  logic [7:0]    RAMDI,
   output logic          RDOE,
   output logic          RAMCS,
   output logic          nRAMWE,
   output logic          MemGnt,
   output logic          Busy,
   output logic          DonePulse
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_SETUP,
      ST_STROBE,
      ST_RECOV
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW-1:0] len_q, len_d;
   logic [7:0]    fill_q, fill_d;
   logic          verify_q, verify_d;
   logic          done_q, done_d;
   logic          mismatch_q, mismatch_d;
   logic          aborted_q, aborted_d;
   logic          abort_pend_q, abort_pend_d;
   logic          miss_q, miss_d;
   logic          done_pulse_q, done_pulse_d;

   logic ctl_wr;
   logic start_req;
   logic abort_req;
   logic slot;

   // Abort always wins over Start when both arrive in one control write.
   always_comb begin
      ctl_wr    = CfgWR && (CfgSel == 3'd7);
      abort_req = ctl_wr && CfgD[1];
      start_req = ctl_wr && CfgD[0] && !CfgD[1];
   end

   always_comb begin
      // NOTE: every variable gets its hold value first so no path leaves one unassigned (no latches).
      state_d      = state_q;
      addr_d       = addr_q;
      len_d        = len_q;
      fill_d       = fill_q;
      verify_d     = verify_q;
      done_d       = done_q;
      mismatch_d   = mismatch_q;
      aborted_d    = aborted_q;
      abort_pend_d = abort_pend_q;
      miss_d       = miss_q;
      done_pulse_d = 1'b0;

      // Parameter registers are only writable while no operation is running.
      if (CfgWR && (state_q == ST_IDLE)) begin
         for (int i = 0; i < AW; i++) begin
            if (int'(CfgSel) == i / 8)     addr_d[i] = CfgD[i % 8];
            if (int'(CfgSel) == i / 8 + 3) len_d[i]  = CfgD[i % 8];
         end
         if (CfgSel == 3'd6) fill_d = CfgD;
      end

      case (state_q)
         ST_IDLE: begin
            if (start_req) begin
               mismatch_d   = 1'b0;
               aborted_d    = 1'b0;
               abort_pend_d = 1'b0;
               miss_d       = 1'b0;
               verify_d     = CfgD[2];
               if (len_q == '0) begin
                  done_d       = 1'b1;
                  done_pulse_d = 1'b1;
               end else begin
                  done_d  = 1'b0;
                  state_d = ST_WAIT;
               end
            end
         end

         ST_WAIT: begin
            if (abort_req) begin
               aborted_d = 1'b1;
               state_d   = ST_IDLE;
            end else if ((S == 3'd1) && !HostReq) begin
               state_d = ST_SETUP;
            end
         end

         ST_SETUP: begin
            if (abort_req) abort_pend_d = 1'b1;
            state_d = ST_STROBE;
         end

         ST_STROBE: begin
            if (abort_req) abort_pend_d = 1'b1;
            miss_d  = verify_q && (RAMDI != fill_q);
            state_d = ST_RECOV;
         end

         ST_RECOV: begin
            abort_pend_d = 1'b0;
            miss_d       = 1'b0;
            state_d      = ST_WAIT;
            // A failed compare freezes the counters so software can read the bad address.
            if (miss_q) begin
               mismatch_d   = 1'b1;
               done_d       = 1'b1;
               done_pulse_d = 1'b1;
               state_d      = ST_IDLE;
            end else begin
               addr_d = addr_q + AW'(1);
               len_d  = len_q - AW'(1);
               if (abort_pend_q || abort_req) begin
                  aborted_d = 1'b1;
                  state_d   = ST_IDLE;
               end else if (len_q == AW'(1)) begin
                  done_d       = 1'b1;
                  done_pulse_d = 1'b1;
                  state_d      = ST_IDLE;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge C7M or posedge RES) begin
      if (RES) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         len_q        <= '0;
         fill_q       <= 8'h00;
         verify_q     <= 1'b0;
         done_q       <= 1'b0;
         mismatch_q   <= 1'b0;
         aborted_q    <= 1'b0;
         abort_pend_q <= 1'b0;
         miss_q       <= 1'b0;
         done_pulse_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         len_q        <= len_d;
         fill_q       <= fill_d;
         verify_q     <= verify_d;
         done_q       <= done_d;
         mismatch_q   <= mismatch_d;
         aborted_q    <= aborted_d;
         abort_pend_q <= abort_pend_d;
         miss_q       <= miss_d;
         done_pulse_q <= done_pulse_d;
      end
   end

   // SRAM strobes decode straight from the state flop so RES drops them at once.
   assign slot      = (state_q == ST_SETUP) || (state_q == ST_STROBE) || (state_q == ST_RECOV);
   assign RAMCS     = slot;
   assign MemGnt    = !slot;
   assign RDOE      = slot && !verify_q;
   assign nRAMWE    = !((state_q == ST_STROBE) && !verify_q);
   assign RAMA      = addr_q;
   assign RAMDO     = fill_q;
   assign Busy      = (state_q != ST_IDLE);
   assign DonePulse = done_pulse_q;

   always_comb begin
      CfgQ = 8'h00;
      case (CfgSel)
         3'd7: CfgQ = {4'b0000, aborted_q, mismatch_q, done_q, Busy};
         3'd6: CfgQ = fill_q;
         default: begin
            for (int i = 0; i < AW; i++) begin
               if (int'(CfgSel) == i / 8)     CfgQ[i % 8] = addr_q[i];
               if (int'(CfgSel) == i / 8 + 3) CfgQ[i % 8] = len_q[i];
            end
         end
      endcase
   end

endmodule

// File: doc/ramdisk_fill_engine.md
Name: ramdisk_fill_engine

Overview:
Background SRAM fill/verify sequencer for the RAM-disk card. It shares the SRAM with the 6502 data port by time-slicing.
- One background byte access per Apple II bus cycle, placed in phase states S1–S3 (PHI1 half), while the 6502 port owns S4–S7.
- Software programs start address, length, fill byte and mode through a byte-wide config port. The engine then clears/fills or verifies the range without 6502 involvement.

Parameters:
AW, 20, SRAM address width (address and length registers are AW bits, byte-addressed as L/M/H).

Ports:
C7M  input  1  7M system clock; all logic on posedge C7M
RES  input  1  asynchronous active-high reset
S  input  3  bus phase counter from the main sequencer (0 = idle, 1..7 within a cycle)
HostReq  input  1  6502 port requests SRAM this cycle
CfgWR  input  1  config write strobe (one C7M cycle)
CfgSel  input  3  config register select
CfgD  input  8  config write data
CfgQ  output  8  config readback data (combinational on CfgSel)
RAMA  output  AW  SRAM address during background slot
RAMDO  output  8  SRAM write data (fill byte)
RAMDI  input  8  SRAM read data
RDOE  output  1  drive RAMDO onto SRAM data bus
RAMCS  output  1  background SRAM chip select
nRAMWE  output  1  SRAM write strobe, active-low
MemGnt  output  1  1 = 6502 port may use SRAM
Busy  output  1  operation in progress
DonePulse  output  1  one-cycle pulse on normal completion or mismatch stop

Behaviour:
Register map (CfgSel):
- 0/1/2: address L/M/H (bits above AW-1 ignored).
- 3/4/5: length L/M/H.
- 6: fill byte.
- 7: control on write (bit0 Start, bit1 Abort, bit2 Verify); status on read.
- Status bits: bit0 Busy, bit1 Done (sticky), bit2 Mismatch, bit3 Aborted, others 0.
- Reads of 0–5 return the live address and remaining length.

Reset:
- All registers 0, FSM IDLE.
- Busy=0, DonePulse=0, RAMCS=0, nRAMWE=1, RDOE=0, MemGnt=1, RAMA=0.

FSM states: IDLE, WAIT, SETUP, STROBE, RECOV.
- IDLE:
  - Start with length≠0 → WAIT; clear Done/Mismatch/Aborted; Busy=1.
  - Start with length=0 → stay IDLE; DonePulse next cycle; Done=1.
- WAIT:
  - At S==1 with HostReq=0 → SETUP.
  - At S==1 with HostReq=1 → slot skipped; stay WAIT for the next cycle.
  - S==0 → stay WAIT.
- SETUP (S1):
  - RAMCS=1, RAMA=address, MemGnt=0.
  - Write mode: RDOE=1.
- STROBE (S2):
  - Write mode: nRAMWE=0.
  - Verify mode: RAMDI sampled at end of this state.
- RECOV (S3):
  - nRAMWE=1, RDOE=0, RAMCS=0 at exit.
  - Address += 1, wrapping modulo 2^AW.
  - Length -= 1.
  - Length reaches 0 → IDLE; DonePulse; Done=1.
  - Otherwise → WAIT.
  - Verify mismatch (RAMDI≠fill) → IDLE; Mismatch=1; DonePulse; Done=1. Address and length are NOT advanced, so address reads back the failing byte.
- MemGnt=0 only in SETUP/STROBE/RECOV.
- Background write latency: SETUP entered at the first C7M edge after S==1 is seen; 3 C7M cycles per byte.
- If S leaves the 1..3 window mid-slot (bus cycle restart), the slot completes anyway; nRAMWE is never held low more than 1 cycle.

Abort:
- In WAIT → IDLE next cycle; Aborted=1; no DonePulse.
- In SETUP/STROBE/RECOV → finish the current byte (counters update), then IDLE with Aborted=1.
- Start and Abort in the same write: Abort wins; no operation starts.

Writes while Busy:
- Writes to CfgSel 0–6 are ignored.
- Control Start is ignored; Abort is honoured.

RES asserted mid-slot: outputs return to reset values immediately (async); nRAMWE=1.

Test Plan:
- Fill: addr=0x00100, len=4, fill=0xA5, Start, S cycling 0..7 → four writes to 0x100–0x103 in S2 with RAMDO=0xA5; DonePulse once; status=0x02; address readback 0x00104.
- Wrap: addr=0xFFFFE, len=3 → writes to 0xFFFFE, 0xFFFFF, 0x00000; final address=0x00001.
- Host contention: HostReq=1 at S==1 of cycle 2 → no RAMCS that cycle; write resumes next cycle; total 5 bus cycles for len=4; MemGnt=1 whenever HostReq is honoured.
- Verify mismatch: SRAM holds 0x00 except 0x203=0x5A; verify fill=0x00, addr=0x200, len=8 → stops; Mismatch=1; address readback 0x00203; remaining length 5.
- Abort mid-slot: Abort written during STROBE of byte 2 (len=10) → byte 2 completes; Busy falls after RECOV; status=0x08; no DonePulse.
- Edge cases:
  - len=0 Start → DonePulse; no RAMCS.
  - Start+Abort together → Busy stays 0.
  - RES during STROBE → nRAMWE=1, RAMCS=0 the same cycle.
